// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions (FSM states, data width, baud divider) for uart_rx/uart_tx/uart_tx_fifo.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO with registered count, full and empty flags.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             push, pop;

    // A full FIFO refuses writes even when a read frees a slot on the same edge.
    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter, 8N1 by default.
// Define UART_TX_FIFO_PARITY_EN for 8E1 framing with an even parity bit.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 12_000_000,
    parameter int BAUD = 9600,
    parameter int FIFO_DEPTH = 16,
    localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [UART_DATA_W-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   tx,
    output logic                   busy,
    output logic [CW-1:0]          fifo_count
);

    localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
    localparam int BW = $clog2(CPB);

    uart_state_t            state, state_n;
    logic [BW-1:0]          baud_cnt, baud_cnt_n;
    logic [2:0]             bit_idx, bit_idx_n;
    logic [UART_DATA_W-1:0] shreg, shreg_n, head;
    logic                   tx_n, pop, empty, full, last;

    sync_fifo #(
        .WIDTH(UART_DATA_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk(clk),
        .rst(rst),
        .wr_data(in_data),
        .wr_en(in_valid),
        .rd_en(pop),
        .rd_data(head),
        .count(fifo_count),
        .full(full),
        .empty(empty)
    );

    assign in_ready = !full;
    assign busy     = (state != IDLE) || !empty;
    assign last     = baud_cnt == BW'(CPB - 1);

`ifdef UART_TX_FIFO_PARITY_EN
    logic parity;

    always_ff @(posedge clk) begin
        if (rst) parity <= 1'b0;
        else if (pop) parity <= ^head;
    end
`endif

    // Each bit period ends on the terminal baud count; the next bit is presented on that same edge.
    always_comb begin
        state_n    = state;
        baud_cnt_n = last ? '0 : baud_cnt + BW'(1);
        bit_idx_n  = bit_idx;
        shreg_n    = shreg;
        tx_n       = tx;
        pop        = 1'b0;
        unique case (state)
            IDLE: begin
                baud_cnt_n = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shreg_n = head;
                    tx_n    = 1'b0;
                    state_n = START;
                end
            end
            START: if (last) begin
                tx_n      = shreg[0];
                shreg_n   = shreg >> 1;
                bit_idx_n = '0;
                state_n   = DATA;
            end
            DATA: if (last) begin
                if (bit_idx == 3'd7) begin
`ifdef UART_TX_FIFO_PARITY_EN
                    tx_n    = parity;
                    state_n = PARITY;
`else
                    tx_n    = 1'b1;
                    state_n = STOP;
`endif
                end else begin
                    tx_n      = shreg[0];
                    shreg_n   = shreg >> 1;
                    bit_idx_n = bit_idx + 3'd1;
                end
            end
`ifdef UART_TX_FIFO_PARITY_EN
            PARITY: if (last) begin
                tx_n    = 1'b1;
                state_n = STOP;
            end
`endif
            STOP: if (last) begin
                pop     = !empty;
                shreg_n = empty ? shreg : head;
                tx_n    = empty;
                state_n = empty ? IDLE : START;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            tx       <= 1'b1;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_cnt_n;
            bit_idx  <= bit_idx_n;
            shreg    <= shreg_n;
            tx       <= tx_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboarded bench; accepted bytes are queued and a line decoder checks every frame.
module tb_uart_tx_fifo;

    localparam int CPB = 16;
`ifdef UART_TX_FIFO_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready, tx, busy;
    logic [4:0] fifo_count;

    logic [7:0] in_data2 = '0;
    logic       in_valid2 = 1'b0;
    logic       in_ready2, tx2, busy2;
    logic [4:0] fifo_count2;

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLK_FREQ(16), .BAUD(1), .FIFO_DEPTH(16)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .tx(tx), .busy(busy), .fifo_count(fifo_count)
    );

    uart_tx_fifo dut_def (
        .clk(clk), .rst(rst), .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
        .tx(tx2), .busy(busy2), .fifo_count(fifo_count2)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] expq[$];
    int         starts[$];
    int         cyc = 0;
    logic       mon_active = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Scoreboard: every accepted byte must later appear on the line, in order.
    initial forever begin
        @(posedge clk);
        if (!rst && in_valid && in_ready) expq.push_back(in_data);
    end

    // Line decoder: one sample per cycle, checks each bit is stable for a full bit period.
    initial begin
        int         mt;
        logic [10:0] fbits;
        logic       shape_bad, bad;
        logic [7:0] exp_b;
        mt = 0;
        fbits = '0;
        shape_bad = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) mon_active = 1'b0;
            else if (!mon_active) begin
                if (tx === 1'b0) begin
                    mon_active = 1'b1;
                    mt = 0;
                    shape_bad = 1'b0;
                    fbits = '0;
                    starts.push_back(cyc);
                end
            end else begin
                mt++;
                if (mt % CPB == 0) fbits[mt / CPB] = tx;
                else if (tx !== fbits[mt / CPB]) shape_bad = 1'b1;
                if (mt == NB * CPB - 1) begin
                    mon_active = 1'b0;
                    checks++;
                    if (expq.size() == 0) begin
                        errors++;
                        $display("FAIL frame: got unexpected byte %02h, expected no frame", fbits[8:1]);
                    end else begin
                        exp_b = expq.pop_front();
                        bad = fbits[8:1] !== exp_b || fbits[0] !== 1'b0 || fbits[NB-1] !== 1'b1 || shape_bad;
`ifdef UART_TX_FIFO_PARITY_EN
                        bad = bad || (fbits[9] !== ^exp_b);
`endif
                        if (bad) begin
                            errors++;
                            $display("FAIL frame: got byte %02h start %b stop %b unstable %b bits %b, expected byte %02h",
                                     fbits[8:1], fbits[0], fbits[NB-1], shape_bad, fbits, exp_b);
                        end
                    end
                end
            end
        end
    end

    // Leaves in_valid high so consecutive calls push on consecutive cycles.
    task automatic push(input logic [7:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data = d;
        while (!in_ready && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 2000) begin
            checks++;
            errors++;
            $display("FAIL push_wait: got in_ready low for %0d cycles, expected it to rise", n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((expq.size() != 0 || mon_active || busy) && n < 20000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_drain"}, n < 20000, 1);
        check({name, "_left"}, expq.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int  n, bad_cycles;
        logic stalled;

        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_count", fifo_count, 0);
        check("rst_ready", in_ready, 1);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Single byte: latency, frame length, busy fall.
        push(8'hA5);
        in_valid = 1'b0;
        check("t1_queued", fifo_count, 1);
        check("t1_tx_idle", tx, 1);
        check("t1_busy", busy, 1);
        @(posedge clk);
        #1;
        check("t1_tx_start", tx, 0);
        check("t1_popped", fifo_count, 0);
        n = 0;
        while (busy && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("t1_busy_len", n, NB * CPB);
        drain("t1");

        // Burst: frames must be back to back.
        starts.delete();
        push(8'h00);
        push(8'hFF);
        push(8'h55);
        in_valid = 1'b0;
        drain("t2");
        check("t2_frames", starts.size(), 3);
        if (starts.size() >= 3) begin
            check("t2_gap01", starts[1] - starts[0], NB * CPB);
            check("t2_gap12", starts[2] - starts[1], NB * CPB);
        end

        // Overfill: 17 accepted before in_ready drops.
        stalled = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!in_ready && !stalled) begin
                stalled = 1'b1;
                check("t3_accepted_at_full", i, 17);
                check("t3_full_count", fifo_count, 16);
            end
            push(8'($urandom));
        end
        in_valid = 1'b0;
        check("t3_stalled", stalled, 1);
        drain("t3");

        // Reset mid-frame at D3 of 0x3C with 5 queued.
        push(8'h3C);
        for (int i = 0; i < 5; i++) push(8'($urandom));
        in_valid = 1'b0;
        repeat (68) @(posedge clk);
        #1;
        check("t4_pre_count", fifo_count, 5);
        rst = 1'b1;
        expq.delete();
        @(posedge clk);
        #1;
        check("t4_tx", tx, 1);
        check("t4_busy", busy, 0);
        check("t4_count", fifo_count, 0);
        check("t4_ready", in_ready, 1);
        rst = 1'b0;
        bad_cycles = 0;
        repeat (300) begin
            @(posedge clk);
            #1;
            if (tx !== 1'b1 || busy !== 1'b0) bad_cycles++;
        end
        check("t4_idle_after", bad_cycles, 0);
        push(8'($urandom));
        in_valid = 1'b0;
        drain("t4");

        // Push and pop on the same edge at stop end.
        push(8'h01);
        push(8'h03);
        in_valid = 1'b0;
        check("t5_count_a", fifo_count, 1);
        repeat (NB * CPB - 1) @(posedge clk);
        #1;
        check("t5_count_b", fifo_count, 1);
        check("t5_stop", tx, 1);
        push(8'($urandom));
        in_valid = 1'b0;
        check("t5_count_c", fifo_count, 1);
        check("t5_ready", in_ready, 1);
        check("t5_next_start", tx, 0);
        drain("t5");

        // Random traffic with random gaps, sometimes long enough to empty the FIFO.
        for (int i = 0; i < 30; i++) begin
            push(8'($urandom));
            in_valid = 1'b0;
            repeat (($urandom % 4 == 0) ? $urandom_range(100, 250) : $urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        drain("rand");

        // Default parameters: one frame lasts NB*1250 cycles.
        in_data2 = 8'h5A;
        in_valid2 = 1'b1;
        @(posedge clk);
        #1;
        in_valid2 = 1'b0;
        n = 0;
        while (tx2 !== 1'b0 && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("def_start", tx2, 0);
        n = 0;
        while (busy2 && n < 20000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("def_frame_len", n, NB * 1250);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
